// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reversal reorder buffer.
package bitrev_pkg;

  typedef logic bank_sel_t;

  function automatic int frame_len(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Mirrors the bit order of a word; pure combinational wiring.
module bit_reverse #(
  parameter int WORD_WIDTH = 3
) (
  input  logic [WORD_WIDTH-1:0] in_word,
  output logic [WORD_WIDTH-1:0] out_word
);

  // bit i of the input lands on bit WORD_WIDTH-1-i of the output
  always_comb begin
    out_word = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      out_word[WORD_WIDTH-1-i] = in_word[i];
    end
  end

endmodule

// File: rtl/bitrev_reorder_buffer.sv
// Ping-pong frame buffer: frames are written in natural order into one bank
// while the other bank is read out in bit-reversed index order.
module bitrev_reorder_buffer
  import bitrev_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            frames_buffered
);

  localparam int N = frame_len(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

  logic [DATA_WIDTH-1:0] mem [2][N];
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  bank_sel_t             wr_bank;
  bank_sel_t             rd_bank;
  logic [1:0]            full;
  logic [1:0]            full_nxt;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  wr_done;
  logic                  rd_done;

  bit_reverse #(.WORD_WIDTH(ADDR_WIDTH)) u_bit_reverse (
    .in_word  (rd_cnt),
    .out_word (rd_addr)
  );

  // Ready/valid come straight from the registered full flags, so there is
  // no combinational path from m_ready to s_ready.
  assign s_ready         = !full[wr_bank];
  assign m_valid         = full[rd_bank];
  assign m_data          = mem[rd_bank][rd_addr];
  assign m_last          = m_valid && (rd_cnt == LAST);
  assign frames_buffered = 2'(full[0]) + 2'(full[1]);

  assign wr_fire = s_valid && s_ready;
  assign rd_fire = m_valid && m_ready;
  assign wr_done = wr_fire && (wr_cnt == LAST);
  assign rd_done = rd_fire && (rd_cnt == LAST);

  // Frame-complete write and read always target different banks, so both
  // flag updates can apply together.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  // Counters, bank pointers and full flags; flush overrides any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
    end else if (flush) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_done ? '0 : wr_cnt + ADDR_WIDTH'(1);
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_done ? '0 : rd_cnt + ADDR_WIDTH'(1);
        if (rd_done) rd_bank <= ~rd_bank;
      end
      full <= full_nxt;
    end
  end

  // Sample storage; cleared only by reset, flush leaves contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (wr_fire && !flush) begin
      mem[wr_bank][wr_cnt] <= s_data;
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// Self-checking bench: frame-level queue model plus literal checks.
module tb_bitrev_reorder_buffer;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [1:0]    frames_buffered;

  bitrev_reorder_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_last          (m_last),
    .frames_buffered (frames_buffered)
  );

  always #5 clk = ~clk;

  typedef logic [DW-1:0] frame_t [N];

  // model: queue of complete frames plus the frame being assembled
  frame_t        fq[$];
  frame_t        cur;
  int            wr_i, rd_i;
  int            tot_wr, tot_rd;

  // observed accepted outputs
  int            out_q[$];
  int            last_q[$];
  int            out_t[$];
  int            cyc;
  logic          prev_hold;
  logic [DW-1:0] prev_data;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int rev(input int i);
    int r = 0;
    for (int b = 0; b < AW; b++) if ((i >> b) & 1) r += 1 << (AW - 1 - b);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    wr_i = 0;
    rd_i = 0;
  endtask

  // What the next clock edge does, judged from the pre-edge model state.
  task automatic model_step(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
    bit rdy, vld;
    if (fl) begin
      model_reset();
      return;
    end
    rdy = fq.size() < 2;
    vld = fq.size() > 0;
    if (vld && mr) begin
      rd_i++;
      tot_rd++;
      if (rd_i == N) begin
        void'(fq.pop_front());
        rd_i = 0;
      end
    end
    if (sv && rdy) begin
      cur[wr_i] = sd;
      wr_i++;
      tot_wr++;
      if (wr_i == N) begin
        fq.push_back(cur);
        wr_i = 0;
      end
    end
  endtask

  task automatic compare();
    chk("s_ready", s_ready, fq.size() < 2);
    chk("m_valid", m_valid, fq.size() > 0);
    chk("frames_buffered", frames_buffered, fq.size());
    if (fq.size() > 0) begin
      chk("m_data", m_data, fq[0][rev(rd_i)]);
      chk("m_last", m_last, rd_i == N - 1);
    end else begin
      chk("m_last_idle", m_last, 0);
    end
    if (prev_hold && m_valid) chk("m_data_stable", m_data, prev_data);
  endtask

  // Drive one cycle at the falling edge, then check after the next edge.
  task automatic tick(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    #1;
    if (m_valid && m_ready && !flush) begin
      out_q.push_back(int'(m_data));
      last_q.push_back(int'(m_last));
      out_t.push_back(cyc);
    end
    prev_hold = m_valid && !mr && !fl;
    prev_data = m_data;
    model_step(sv, sd, mr, fl);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic clear_out();
    out_q.delete();
    last_q.delete();
    out_t.delete();
  endtask

  int pat[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int min_rdy;
  int guard;

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    prev_hold = 1'b0; prev_data = '0; cyc = 0; tot_wr = 0; tot_rd = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frames", frames_buffered, 0);
    chk("rst_s_ready", s_ready, 1);
    @(negedge clk);
    compare();

    // 1: single frame 0..7
    clear_out();
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) chk("t1_pre_valid", m_valid, 0);
      tick(1, DW'(i), 1, 0);
    end
    chk("t1_valid_after7", m_valid, 1);
    chk("t1_frames_1", frames_buffered, 1);
    for (int i = 0; i < N + 2; i++) tick(0, 0, 1, 0);
    chk("t1_count", out_q.size(), N);
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      chk("t1_data", out_q[i], pat[i]);
      chk("t1_last", last_q[i], i == N - 1);
    end
    chk("t1_frames_0", frames_buffered, 0);

    // 2: back-to-back frames, no bubbles
    clear_out();
    min_rdy = 1;
    for (int i = 0; i < 2 * N; i++) begin
      if (!s_ready) min_rdy = 0;
      tick(1, DW'(i), 1, 0);
    end
    for (int i = 0; i < N + 2; i++) tick(0, 0, 1, 0);
    chk("t2_s_ready_held", min_rdy, 1);
    chk("t2_count", out_q.size(), 2 * N);
    if (out_q.size() == 2 * N) begin
      for (int i = 0; i < 2 * N; i++) chk("t2_data", out_q[i], (i / N) * N + pat[i % N]);
      chk("t2_no_bubble", out_t[2 * N - 1] - out_t[0], 2 * N - 1);
    end

    // 3: fill both banks, then release
    for (int i = 0; i < 2 * N; i++) tick(1, DW'(100 + i), 0, 0);
    chk("t3_s_ready_low", s_ready, 0);
    chk("t3_frames_2", frames_buffered, 2);
    for (int i = 0; i < N; i++) begin
      tick(0, 0, 1, 0);
      if (i == N - 2) chk("t3_ready_before_last", s_ready, 0);
    end
    chk("t3_ready_after_last", s_ready, 1);
    chk("t3_frames_1", frames_buffered, 1);
    for (int i = 0; i < N + 1; i++) tick(0, 0, 1, 0);

    // 4: random stalls over 10 frames
    tot_wr = 0; tot_rd = 0; guard = 0;
    while (tot_rd < 10 * N && guard < 3000) begin
      tick((tot_wr < 10 * N) && ($urandom_range(0, 3) != 0), DW'($urandom),
           $urandom_range(0, 2) != 0, 0);
      guard++;
    end
    chk("t4_all_read", tot_rd, 10 * N);
    chk("t4_frames_0", frames_buffered, 0);

    // 5: flush after 5 samples
    for (int i = 0; i < 5; i++) tick(1, DW'(200 + i), 1, 0);
    tick(1, DW'(300), 1, 1);
    chk("t5_flush_frames", frames_buffered, 0);
    clear_out();
    for (int i = 0; i < N; i++) tick(1, DW'(i), 1, 0);
    for (int i = 0; i < N + 1; i++) tick(0, 0, 1, 0);
    chk("t5_count", out_q.size(), N);
    for (int i = 0; i < N && i < out_q.size(); i++) chk("t5_data", out_q[i], pat[i]);

    // 6: async reset mid-read
    for (int i = 0; i < N; i++) tick(1, DW'(50 + i), 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
    chk("t6_rd_pos", rd_i, 3);
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", m_valid, 0);
    chk("t6_async_frames", frames_buffered, 0);
    chk("t6_async_ready", s_ready, 1);
    model_reset();
    prev_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare();
    @(negedge clk);
    clear_out();
    for (int i = 0; i < N; i++) tick(1, DW'(16 + i), 1, 0);
    for (int i = 0; i < N + 1; i++) tick(0, 0, 1, 0);
    chk("t6_count", out_q.size(), N);
    for (int i = 0; i < N && i < out_q.size(); i++) chk("t6_data", out_q[i], 16 + pat[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
